eda_region_stack: RTL

- LIFO of pixel addresses for region growing: holds neighbours that eda_iterated_ram has just marked as iterated, and returns them one at a time as the next centre pixel.
- Sits directly downstream of the neighbour-compare logic that drives eda_iterated_ram's push_positions.
- Uses the same 8 neighbour addresses and push_positions mask, so every pushed pixel is marked iterated in the same cycle.
- Accepts up to 8 pushes per cycle. Pops at most one per cycle.

---
 rtl/eda_region_stack_pkg.sv | 33 +++
 rtl/eda_push_compactor.sv | 33 +++
 rtl/eda_region_stack.sv | 135 +++++++++++++
 3 files changed

// File: rtl/eda_region_stack_pkg.sv
// eda_region_stack_pkg
//   Shared configuration for the region-growing stack.
//   - Default image geometry and window size.
//   - Default stack depth.
//   - Neighbour index constants. The ordering matches the addr_arr
//     layout in eda_iterated_ram, so push_positions bit k names the
//     same neighbour in both blocks.
//   - A helper that sizes the per-neighbour offset / popcount fields.
package eda_region_stack_pkg;

   localparam int CFG_M            = 8;
   localparam int CFG_N            = 8;
   localparam int CFG_WINDOW_WIDTH = 9;
   localparam int CFG_STACK_DEPTH  = CFG_M * CFG_N;

   localparam int NUM_NB = CFG_WINDOW_WIDTH - 1;

   // push_positions bit index of each neighbour
   localparam int NB_UPLEFT    = 7;
   localparam int NB_UP        = 6;
   localparam int NB_UPRIGHT   = 5;
   localparam int NB_LEFT      = 4;
   localparam int NB_RIGHT     = 3;
   localparam int NB_DOWNLEFT  = 2;
   localparam int NB_DOWN      = 1;
   localparam int NB_DOWNRIGHT = 0;

   // Width that can hold a popcount of nb bits (0..nb)
   function automatic int nb_off_w(input int nb);
      return $clog2(nb + 1);
   endfunction

endpackage

// File: rtl/eda_push_compactor.sv
// eda_push_compactor
//   Combinational prefix popcount over the neighbour push mask.
//   Ports:
//     mask    in   NB bits         neighbour push mask
//     offset  out  NB x OFF_W      write offset of each bit
//                                  (popcount of the lower mask bits)
//     total   out  OFF_W           popcount of the whole mask
//   Set bits therefore pack densely in ascending index order: the lowest
//   set bit gets offset 0 and the highest set bit gets offset total-1.
module eda_push_compactor
   import eda_region_stack_pkg::*;
#(
   parameter int NB    = NUM_NB,
   parameter int OFF_W = nb_off_w(NB)
) (
   input  logic [NB-1:0]            mask,
   output logic [NB-1:0][OFF_W-1:0] offset,
   output logic [OFF_W-1:0]         total
);

   logic [OFF_W-1:0] acc;

   always_comb begin
      acc    = '0;
      offset = '0;
      for (int k = 0; k < NB; k++) begin
         offset[k] = acc;
         acc       = acc + OFF_W'(mask[k]);
      end
      total = acc;
   end

endmodule

// File: rtl/eda_region_stack.sv
// eda_region_stack
//   LIFO of pixel addresses for region growing. It takes the neighbours
//   that eda_iterated_ram marks as iterated, up to 8 per cycle. It hands
//   them back one at a time as the next centre pixel.
//   Ports:
//     clk                      in   clock, all state on posedge
//     reset                    in   synchronous active-high reset
//     clear                    in   empty the stack, clear overflow
//     upleft_addr..downright_addr
//                              in   8 neighbour addresses
//     push_positions           in   push mask, bit 7 upleft .. 0 downright
//     pop                      in   remove the top entry (ignored if empty)
//     top_addr                 out  mem[count-1], 0 when empty
//     empty / full             out  count == 0 / count == DEPTH
//     count                    out  occupancy
//     overflow                 out  sticky: a push burst was dropped
//   A pop in the same cycle as a push frees its slot first. The burst is
//   then written from that lowered base. A burst that does not fit is
//   dropped whole, so the stack never holds only part of a neighbourhood.
module eda_region_stack
   import eda_region_stack_pkg::*;
#(
   parameter int M            = CFG_M,
   parameter int N            = CFG_N,
   parameter int WINDOW_WIDTH = CFG_WINDOW_WIDTH,
   parameter int ADDR_WIDTH   = $clog2(M) + $clog2(N),
   parameter int DEPTH        = CFG_STACK_DEPTH,
   parameter int CNT_WIDTH    = $clog2(DEPTH + 1)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clear,
   input  logic [ADDR_WIDTH-1:0]   upleft_addr,
   input  logic [ADDR_WIDTH-1:0]   up_addr,
   input  logic [ADDR_WIDTH-1:0]   upright_addr,
   input  logic [ADDR_WIDTH-1:0]   left_addr,
   input  logic [ADDR_WIDTH-1:0]   right_addr,
   input  logic [ADDR_WIDTH-1:0]   downleft_addr,
   input  logic [ADDR_WIDTH-1:0]   down_addr,
   input  logic [ADDR_WIDTH-1:0]   downright_addr,
   input  logic [WINDOW_WIDTH-2:0] push_positions,
   input  logic                    pop,
   output logic [ADDR_WIDTH-1:0]   top_addr,
   output logic                    empty,
   output logic                    full,
   output logic [CNT_WIDTH-1:0]    count,
   output logic                    overflow
);

   localparam int NB    = WINDOW_WIDTH - 1;
   localparam int OFF_W = nb_off_w(NB);
   // One spare bit so base + burst can exceed DEPTH without wrapping
   localparam int EXT_W = CNT_WIDTH + 1;

   logic [NB-1:0][ADDR_WIDTH-1:0] addr_arr;
   logic [NB-1:0][OFF_W-1:0]      offset;
   logic [OFF_W-1:0]              total;

   logic                          pop_ok;
   logic [EXT_W-1:0]              base;
   logic [EXT_W-1:0]              need;
   logic                          drop;
   logic [NB-1:0]                 wr_en;
   logic [NB-1:0][EXT_W-1:0]      wr_idx;

   logic [ADDR_WIDTH-1:0]         mem [DEPTH];

   assign addr_arr[NB_UPLEFT]    = upleft_addr;
   assign addr_arr[NB_UP]        = up_addr;
   assign addr_arr[NB_UPRIGHT]   = upright_addr;
   assign addr_arr[NB_LEFT]      = left_addr;
   assign addr_arr[NB_RIGHT]     = right_addr;
   assign addr_arr[NB_DOWNLEFT]  = downleft_addr;
   assign addr_arr[NB_DOWN]      = down_addr;
   assign addr_arr[NB_DOWNRIGHT] = downright_addr;

   eda_push_compactor #(
      .NB    (NB),
      .OFF_W (OFF_W)
   ) u_compactor (
      .mask   (push_positions),
      .offset (offset),
      .total  (total)
   );

   // Next-state datapath: pop first, then the burst lands on top of base
   always_comb begin
      pop_ok = pop & ~empty;
      base   = {1'b0, count} - EXT_W'(pop_ok);
      need   = base + EXT_W'(total);
      drop   = need > EXT_W'(DEPTH);
      wr_en  = '0;
      wr_idx = '0;
      for (int k = 0; k < NB; k++) begin
         wr_en[k]  = push_positions[k] & ~drop & ~reset & ~clear;
         wr_idx[k] = base + EXT_W'(offset[k]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count    <= '0;
         overflow <= 1'b0;
      end else if (drop) begin
         count    <= base[CNT_WIDTH-1:0];
         overflow <= 1'b1;
      end else begin
         count    <= need[CNT_WIDTH-1:0];
      end
   end

   // Storage is not reset; count alone defines which entries are live.
   // Offsets are distinct for distinct set bits, so at most one
   // neighbour matches a given entry.
   always_ff @(posedge clk) begin
      for (int e = 0; e < DEPTH; e++) begin
         for (int k = 0; k < NB; k++) begin
            if (wr_en[k] && (wr_idx[k] == EXT_W'(e)))
               mem[e] <= addr_arr[k];
         end
      end
   end

   // Top-of-stack read as a one-hot mux on count; empty falls through to 0
   always_comb begin
      empty    = (count == '0);
      full     = (count == CNT_WIDTH'(DEPTH));
      top_addr = '0;
      for (int e = 0; e < DEPTH; e++) begin
         if (count == CNT_WIDTH'(e + 1))
            top_addr = mem[e];
      end
   end

endmodule
